// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: digit count, BCD limits and the
// converter state encoding used by both keypad-side and display-side paths.
package calc_pkg;

    localparam int DIGITS_DEFAULT = 8;
    localparam logic [3:0] NIBBLE_MAX = 4'd9;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic nibble_valid(input logic [3:0] nib);
        return nib <= NIBBLE_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/done handshake bundle between the keypad front end and the BCD-to-binary
// converter; master issues operands, slave returns the converted value.
interface bcd_to_binary_if
    import calc_pkg::*;
#(
    parameter int W = 4 * DIGITS_DEFAULT
);
    logic         start;
    logic [W-1:0] bcd_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    modport master (
        output start, bcd_in,
        input  busy, done, err, result
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, result
    );
endinterface

// File: rtl/bcd_nibble_adj.sv
// Per-digit correction step of reverse double dabble: a shifted digit of 8 or
// more had a carry-in worth 8 that must be worth 5, so take 3 back off.
module bcd_nibble_adj (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);
    assign nib_out = (nib_in >= 4'd8) ? nib_in - 4'd3 : nib_in;
endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per
// clock) with invalid-digit detection and a start/done handshake.
module bcd_to_binary
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int W      = 4 * DIGITS
) (
    input  logic            clk,
    input  logic            rst,
    bcd_to_binary_if.slave  bus
);
    localparam int CW = $clog2(W) + 1;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  bcd_reg;
    logic [W-1:0]  bin_reg;
    logic [W-1:0]  bcd_shift;
    logic [W-1:0]  bcd_adj;
    logic [W-1:0]  bin_shift;
    logic [CW-1:0] cnt;
    logic          in_valid;
    logic          last;
    logic          done_reg;
    logic          err_reg;
    logic [W-1:0]  result_reg;

    // The pair {bcd_reg, bin_reg} shifts right as one 2W-bit register.
    assign bcd_shift = {1'b0, bcd_reg[W-1:1]};
    assign bin_shift = {bcd_reg[0], bin_reg[W-1:1]};
    assign last      = (cnt == CW'(W - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_in  (bcd_shift[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!nibble_valid(bus.bcd_in[4*i +: 4])) begin
                in_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Invalid operands are answered directly from IDLE without iterating.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && in_valid) state_next = SHIFT;
            SHIFT:   if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg    <= '0;
            bin_reg    <= '0;
            cnt        <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (in_valid) begin
                            bcd_reg <= bus.bcd_in;
                            bin_reg <= '0;
                            cnt     <= '0;
                            err_reg <= 1'b0;
                        end else begin
                            result_reg <= '0;
                            err_reg    <= 1'b1;
                            done_reg   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= bin_shift;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        result_reg <= bin_shift;
                        done_reg   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = done_reg;
    assign bus.err    = err_reg;
    assign bus.result = result_reg;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed-vector and sequence bench for bcd_to_binary; inputs change and
// outputs are sampled on the falling clock edge.
module tb_bcd_to_binary;
    import calc_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bcd_to_binary_if #(.W(W)) bus ();

    bcd_to_binary #(.DIGITS(8), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic [31:0] exp_result;
        logic        exp_err;
        int          exp_adv;
        int          exp_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle T+1, with start low again.
    task automatic applyStimulus(input logic [31:0] v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = v;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic waitDone(output int adv, output int busy_cnt);
        adv      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && adv < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            adv++;
        end
        if (adv >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=none expected=done");
        end
    endtask

    task automatic runVector(input string name, input logic [31:0] v, input logic [31:0] exp_res,
                             input logic exp_err, input int exp_adv, input int exp_busy);
        int adv;
        int bc;
        applyStimulus(v);
        waitDone(adv, bc);
        checkOutput({name, "_result"}, bus.result, exp_res);
        checkOutput({name, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        checkOutput({name, "_latency"}, adv, exp_adv);
        checkOutput({name, "_busy_cycles"}, bc, exp_busy);
        @(negedge clk);
        checkOutput({name, "_done_width"}, {31'd0, bus.done}, 32'd0);
        checkOutput({name, "_err_held"}, {31'd0, bus.err}, {31'd0, exp_err});
    endtask

    initial begin
        int adv;
        int bc;
        int done_seen;
        logic [31:0] rbcd;
        logic [31:0] rval;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32, 32};
        vecs[1]  = '{32'h0000_1234, 32'h0000_04D2, 1'b0, 32, 32};
        vecs[2]  = '{32'h9999_9999, 32'h05F5_E0FF, 1'b0, 32, 32};
        vecs[3]  = '{32'h0000_001A, 32'h0000_0000, 1'b1, 0, 0};
        vecs[4]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32, 32};
        vecs[5]  = '{32'h0000_0010, 32'h0000_000A, 1'b0, 32, 32};
        vecs[6]  = '{32'h1234_5678, 32'h00BC_614E, 1'b0, 32, 32};
        vecs[7]  = '{32'hF000_0000, 32'h0000_0000, 1'b1, 0, 0};
        vecs[8]  = '{32'h9000_0000, 32'h055D_4A80, 1'b0, 32, 32};
        vecs[9]  = '{32'h0000_0009, 32'h0000_0009, 1'b0, 32, 32};
        vecs[10] = '{32'h0000_0500, 32'h0000_01F4, 1'b0, 32, 32};
        vecs[11] = '{32'h0A00_0000, 32'h0000_0000, 1'b1, 0, 0};
        vecs[12] = '{32'h8765_4321, 32'h0539_7FB1, 1'b0, 32, 32};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);

        for (int i = 0; i < 13; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_result,
                      vecs[i].exp_err, vecs[i].exp_adv, vecs[i].exp_busy);
        end

        // Back-to-back: restart in the very cycle done is visible.
        applyStimulus(32'h0000_1234);
        waitDone(adv, bc);
        checkOutput("b2b_first_result", bus.result, 32'h0000_04D2);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h9999_9999;
        @(negedge clk);
        bus.start  = 1'b0;
        waitDone(adv, bc);
        checkOutput("b2b_second_latency", adv, 32);
        checkOutput("b2b_second_result", bus.result, 32'h05F5_E0FF);

        // Start during SHIFT is ignored and does not disturb the first operand.
        applyStimulus(32'h0000_0500);
        repeat (9) @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h0000_0007;
        @(negedge clk);
        bus.start  = 1'b0;
        waitDone(adv, bc);
        checkOutput("ignored_start_latency", adv, 22);
        checkOutput("ignored_start_result", bus.result, 32'h0000_01F4);
        @(negedge clk);
        repeat (40) begin
            checkOutput("ignored_start_no_second", {31'd0, bus.done | bus.busy}, 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of a conversion discards it entirely.
        applyStimulus(32'h8765_4321);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("midreset_err", {31'd0, bus.err}, 32'd0);
        checkOutput("midreset_result", bus.result, 32'd0);
        done_seen = 0;
        repeat (40) begin
            if (bus.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checkOutput("midreset_no_done", done_seen, 0);
        runVector("after_reset", 32'h8765_4321, 32'h0539_7FB1, 1'b0, 32, 32);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.bcd_in = 32'h0000_0042;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        done_seen = 0;
        repeat (40) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        checkOutput("rst_start_dropped", done_seen, 0);
        checkOutput("rst_start_result", bus.result, 32'd0);

        // Random sweep against a decimal reference built alongside the digits.
        for (int n = 0; n < 1000; n++) begin
            rbcd = '0;
            rval = '0;
            for (int d = 7; d >= 0; d--) begin
                int dig;
                dig  = int'($urandom_range(0, 9));
                rbcd = {rbcd[27:0], 4'(dig)};
                rval = rval * 32'd10 + 32'(dig);
            end
            applyStimulus(rbcd);
            waitDone(adv, bc);
            checkOutput($sformatf("rand%0d_result", n), bus.result, rval);
            @(negedge clk);
            checkOutput($sformatf("rand%0d_done_width", n), {31'd0, bus.done}, 32'd0);
        end

        $display("[TB] test sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential BCD-to-binary converter for the calculator datapath. It turns an 8-digit packed-BCD operand from keypad entry into a 32-bit unsigned binary value for the ALU, the inverse of the display-side binary-to-BCD path. The conversion is reverse double dabble, one bit per clock, with a start/done handshake and invalid-digit detection.

## Interface

Parameters:
- DIGITS, default 8: number of packed BCD digits.
- W, default 4*DIGITS (32): BCD input width, binary output width and iteration count.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  conversion request, single-cycle pulse. Sampled only in IDLE.
- bcd_in  in  W  packed BCD operand. Digit 0 is in [3:0]. Sampled on an accepted start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when result and err are updated.
- err  out  1  high if the last accepted operand had any nibble > 9. Held until the next accepted start.
- result  out  W  binary value of the last conversion. Held until the next done.

## Operation

- States: IDLE and SHIFT.
- Reset values: state=IDLE, busy=0, done=0, err=0, result=0, iteration count=0.
- IDLE with start=1 and every nibble of bcd_in ≤ 9:
  - load bcd_reg=bcd_in, bin_reg=0, cnt=0, err<=0;
  - go to SHIFT.
- IDLE with start=1 and any nibble > 9:
  - result<=0, err<=1, done<=1;
  - stay in IDLE and start no iteration.
- SHIFT, one iteration per cycle:
  - shift the 2W-bit pair {bcd_reg, bin_reg} right by 1 (bcd_reg MSB gets 0);
  - then, in every BCD nibble of the shifted bcd_reg, any nibble ≥ 8 gets 3 subtracted (4-bit, no borrow between nibbles);
  - cnt increments.
- Final iteration (cnt == W-1):
  - result<= final bin_reg, done<=1;
  - return to IDLE.
- busy = (state == SHIFT). It is a registered state decode, not a combinational start path.
- start while in SHIFT is ignored. No queuing, no abort.
- bcd_in changes after acceptance have no effect.
- Output range: 0 to 99,999,999 for DIGITS=8. Upper bits of result are zero.

## Timing

- Valid start accepted in cycle T:
  - busy=1 in cycles T+1 through T+W (32 cycles);
  - done=1 and result valid in cycle T+W+1;
  - busy=0 in that cycle.
- A new start in the done cycle (T+W+1) is accepted: back-to-back throughput is one conversion per W+1 cycles.
- Invalid start in cycle T: done=1 and err=1 in T+1, busy never asserts.
- done is exactly one cycle wide. It never asserts without a preceding accepted start.
- rst asserted in any cycle, including mid-SHIFT, applies all reset values on that edge. The in-flight conversion is discarded and no done follows.
- rst and start in the same cycle: reset wins and start is dropped.

## Structure

- Shared package calc_pkg holds:
  - the DIGITS default;
  - the state enum (IDLE, SHIFT);
  - the BCD nibble-valid constant (9).
  - The display-side converter uses the same DIGITS constant.
- Sub-module bcd_nibble_adj: 4-bit combinational corrector, out = (in ≥ 8) ? in − 3 : in. Instantiated DIGITS times by generate.
- Top level holds:
  - the FSM;
  - the 6-bit iteration counter (sized clog2(W)+1);
  - the bcd/bin shift registers;
  - the output registers.

## Test plan

- Reset, then start with bcd_in=0x00000000 at T: busy T+1..T+32, done at T+33, result=0, err=0.
- bcd_in=0x00001234: result=0x000004D2 at T+33. Immediately restart in the done cycle with 0x99999999: result=0x05F5E0FF exactly 33 cycles later.
- bcd_in=0x0000001A (invalid digit A): done and err at T+1, result=0, busy stays 0. The next valid start clears err.
- Start with 0x00000500, then pulse start with 0x00000007 at T+10: the second start is ignored and result=0x000001F4.
- Start 0x87654321, assert rst at T+15 for one cycle: all outputs 0 from T+16 and no done pulse. A fresh start then gives result=0x05397FB1.
- Randomised sweep of 1000 valid operands against a reference model: result equals the decimal value every time, and done width is always 1.
